ex_mem_result_reg: RTL and testbench
====================================

Name: ex_mem_result_reg

Overview:
- Execute-to-memory boundary register for the 16-bit pipelined core.
- Selects the final execute-stage result from the ALU output, the bit-reverse unit output, the load-immediate value and the set-condition flag.
- Registers that result with its destination/control bits, and exposes the registered result for EX-to-EX forwarding.
- Handles stall hold, flush-to-bubble and sticky halt propagation toward memory and writeback.

Parameters:
- DATA_W, 16, datapath width.
- REG_W, 3, register-select width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- stall  input  1  hold all registered state this cycle.
- flush  input  1  load a bubble this cycle.
- in_valid  input  1  execute stage holds a real instruction.
- alu_out  input  DATA_W  ALU result.
- btr_out  input  DATA_W  bit-reverse unit result.
- imm_val  input  DATA_W  load-immediate value, already formed upstream.
- set_cond  input  1  set-condition compare result.
- result_sel  input  2  00 ALU, 01 bit-reverse, 10 immediate, 11 set-condition.
- in_write_reg  input  REG_W  destination register.
- in_reg_write  input  1  writeback enable.
- in_mem_read  input  1  load.
- in_mem_write  input  1  store.
- in_store_data  input  DATA_W  store data.
- in_halt  input  1  halt instruction.
- out_valid  output  1  registered valid.
- out_result  output  DATA_W  registered result; also the memory address.
- out_store_data  output  DATA_W  registered store data.
- out_write_reg  output  REG_W  registered destination.
- out_reg_write  output  1  registered writeback enable, gated by valid.
- out_mem_read  output  1  registered load, gated by valid.
- out_mem_write  output  1  registered store, gated by valid.
- out_halt  output  1  sticky halt.
- fwd_valid  output  1  out_valid & out_reg_write.
- fwd_reg  output  REG_W  equals out_write_reg.
- fwd_data  output  DATA_W  equals out_result.

Behaviour:
- Result mux (combinational):
  - sel 11 produces {(DATA_W-1)'b0, set_cond}.
  - All other select values pass the selected input unmodified.
  - No arithmetic is performed in this block.
- Reset: every registered output is 0, and the internal halted flag is 0.
- Per-clock priority: rst > flush > stall > halted > load.
  - flush: loads a bubble, even when stall is also high.
  - stall (flush low): every registered output keeps its value; halted is unchanged.
  - halted=1 (no flush/stall): loads a bubble; in_valid is ignored.
  - load: loads the mux result and all in_* fields.
    - The control bits (reg_write, mem_read, mem_write, halt) are ANDed with in_valid.
    - out_valid <= in_valid.
- Bubble: out_valid, out_reg_write, out_mem_read and out_mem_write are 0; out_result, out_store_data and out_write_reg are 0.
- Halt:
  - halted is set when a load occurs with in_valid & in_halt.
  - The halt instruction itself occupies the register for that cycle.
  - out_halt asserts on the same edge and stays 1 until rst.
  - flush and stall never clear halted. A flush on the same edge as a halt load wins, so halted is not set.
- Latency: exactly 1 cycle from inputs to out_*. Forwarding outputs are pure wires from the registers, with no extra delay.
- in_mem_read and in_mem_write both 1: both are registered as given; no checking in this block.
- Reset asserted mid-stall or mid-halt: all state clears on that edge; loading resumes on the next non-stall edge.

Test Plan:
- Reset, then in_valid=1, sel=01, btr_out=16'h8001, in_write_reg=3, in_reg_write=1 -> next cycle: out_valid=1, out_result=16'h8001, fwd_valid=1, fwd_reg=3, fwd_data=16'h8001.
- sel=11, set_cond=1, alu_out=16'hFFFF -> out_result=16'h0001. Then sel=10, imm_val=16'hFF80 -> out_result=16'hFF80.
- Load 16'h1234, then stall=1 for 3 cycles with changing inputs -> outputs stay 16'h1234 throughout. stall=1 and flush=1 together -> bubble: out_valid=0, out_result=0, fwd_valid=0.
- in_valid=0 with in_reg_write=1, in_mem_write=1 -> out_valid=0, out_reg_write=0, out_mem_write=0.
- Valid halt loaded -> out_halt=1 and out_valid=1 for one cycle. Following valid adds -> out_valid=0 every cycle and out_halt stays 1. Then rst=1 -> out_halt=0 next cycle.
- Halt load coincident with flush=1 -> out_halt=0 and the next valid instruction loads normally.

Source files
------------

// File: rtl/ex_mem_result_reg_if.sv
// ex_mem_result_reg_if: execute-to-memory boundary signal bundle
interface ex_mem_result_reg_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
);
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] btr_out;
  logic [DATA_W-1:0] imm_val;
  logic              set_cond;
  logic [1:0]        result_sel;
  logic [REG_W-1:0]  in_write_reg;
  logic              in_reg_write;
  logic              in_mem_read;
  logic              in_mem_write;
  logic [DATA_W-1:0] in_store_data;
  logic              in_halt;
  logic              out_valid;
  logic [DATA_W-1:0] out_result;
  logic [DATA_W-1:0] out_store_data;
  logic [REG_W-1:0]  out_write_reg;
  logic              out_reg_write;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              out_halt;
  logic              fwd_valid;
  logic [REG_W-1:0]  fwd_reg;
  logic [DATA_W-1:0] fwd_data;
  modport master (
    output stall, flush, in_valid, alu_out, btr_out, imm_val, set_cond, result_sel,
           in_write_reg, in_reg_write, in_mem_read, in_mem_write, in_store_data, in_halt,
    input  out_valid, out_result, out_store_data, out_write_reg, out_reg_write,
           out_mem_read, out_mem_write, out_halt, fwd_valid, fwd_reg, fwd_data
  );
  modport slave (
    input  stall, flush, in_valid, alu_out, btr_out, imm_val, set_cond, result_sel,
           in_write_reg, in_reg_write, in_mem_read, in_mem_write, in_store_data, in_halt,
    output out_valid, out_result, out_store_data, out_write_reg, out_reg_write,
           out_mem_read, out_mem_write, out_halt, fwd_valid, fwd_reg, fwd_data
  );
endinterface

// File: rtl/ex_mem_result_reg.sv
// ex_mem_result_reg: EX/MEM pipeline register with result select, stall, flush and sticky halt
module ex_mem_result_reg #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input logic clk,
  input logic rst,
  ex_mem_result_reg_if.slave bus
);
  logic [DATA_W-1:0] result;
  logic              halted;
  always_comb begin
    result = bus.result_sel == 2'b00 ? bus.alu_out :
             bus.result_sel == 2'b01 ? bus.btr_out :
             bus.result_sel == 2'b10 ? bus.imm_val :
             {{(DATA_W-1){1'b0}}, bus.set_cond};
  end
  always_ff @(posedge clk) begin
    if (rst || bus.flush || (halted && !bus.stall)) begin
      bus.out_valid      <= 1'b0;
      bus.out_result     <= '0;
      bus.out_store_data <= '0;
      bus.out_write_reg  <= '0;
      bus.out_reg_write  <= 1'b0;
      bus.out_mem_read   <= 1'b0;
      bus.out_mem_write  <= 1'b0;
    end else if (!bus.stall) begin
      bus.out_valid      <= bus.in_valid;
      bus.out_result     <= result;
      bus.out_store_data <= bus.in_store_data;
      bus.out_write_reg  <= bus.in_write_reg;
      bus.out_reg_write  <= bus.in_reg_write & bus.in_valid;
      bus.out_mem_read   <= bus.in_mem_read & bus.in_valid;
      bus.out_mem_write  <= bus.in_mem_write & bus.in_valid;
    end
  end
  always_ff @(posedge clk) begin
    if (rst)
      halted <= 1'b0;
    else if (!bus.flush && !bus.stall && bus.in_valid && bus.in_halt)
      halted <= 1'b1;
  end
  assign bus.out_halt  = halted;
  assign bus.fwd_valid = bus.out_valid & bus.out_reg_write;
  assign bus.fwd_reg   = bus.out_write_reg;
  assign bus.fwd_data  = bus.out_result;
endmodule

// File: tb/tb_ex_mem_result_reg.sv
// tb_ex_mem_result_reg: directed self-checking bench for ex_mem_result_reg
module tb_ex_mem_result_reg;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  ex_mem_result_reg_if #(.DATA_W(16), .REG_W(3)) bus ();
  ex_mem_result_reg #(.DATA_W(16), .REG_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    bus.stall = 0; bus.flush = 0; bus.in_valid = 0; bus.alu_out = 0; bus.btr_out = 0;
    bus.imm_val = 0; bus.set_cond = 0; bus.result_sel = 0; bus.in_write_reg = 0;
    bus.in_reg_write = 0; bus.in_mem_read = 0; bus.in_mem_write = 0;
    bus.in_store_data = 0; bus.in_halt = 0;
    step(); step();
    chk("rst_valid", 16'(bus.out_valid), 16'h0);
    chk("rst_result", bus.out_result, 16'h0);
    chk("rst_halt", 16'(bus.out_halt), 16'h0);
    chk("rst_fwd_valid", 16'(bus.fwd_valid), 16'h0);
    rst = 0;
    bus.in_valid = 1; bus.result_sel = 2'b01; bus.btr_out = 16'h8001; bus.alu_out = 16'h5555;
    bus.in_write_reg = 3'd3; bus.in_reg_write = 1;
    step();
    chk("btr_valid", 16'(bus.out_valid), 16'h1);
    chk("btr_result", bus.out_result, 16'h8001);
    chk("btr_fwd_valid", 16'(bus.fwd_valid), 16'h1);
    chk("btr_fwd_reg", 16'(bus.fwd_reg), 16'h3);
    chk("btr_fwd_data", bus.fwd_data, 16'h8001);
    bus.result_sel = 2'b11; bus.set_cond = 1; bus.alu_out = 16'hFFFF;
    step();
    chk("setc_result", bus.out_result, 16'h0001);
    bus.result_sel = 2'b10; bus.imm_val = 16'hFF80;
    step();
    chk("imm_result", bus.out_result, 16'hFF80);
    bus.result_sel = 2'b00; bus.alu_out = 16'h1234; bus.in_store_data = 16'hABCD;
    bus.in_mem_write = 1; bus.in_write_reg = 3'd5;
    step();
    chk("alu_result", bus.out_result, 16'h1234);
    chk("alu_store", bus.out_store_data, 16'hABCD);
    chk("alu_mem_write", 16'(bus.out_mem_write), 16'h1);
    chk("alu_write_reg", 16'(bus.out_write_reg), 16'h5);
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      bus.alu_out = 16'(i * 16'h1111 + 16'h0F0F); bus.in_valid = 1'(i & 1);
      step();
      chk("stall_result", bus.out_result, 16'h1234);
      chk("stall_valid", 16'(bus.out_valid), 16'h1);
    end
    bus.flush = 1;
    step();
    chk("flush_valid", 16'(bus.out_valid), 16'h0);
    chk("flush_result", bus.out_result, 16'h0);
    chk("flush_fwd_valid", 16'(bus.fwd_valid), 16'h0);
    chk("flush_store", bus.out_store_data, 16'h0);
    bus.flush = 0; bus.stall = 0;
    bus.in_valid = 0; bus.in_reg_write = 1; bus.in_mem_write = 1;
    step();
    chk("inv_valid", 16'(bus.out_valid), 16'h0);
    chk("inv_reg_write", 16'(bus.out_reg_write), 16'h0);
    chk("inv_mem_write", 16'(bus.out_mem_write), 16'h0);
    bus.in_valid = 1; bus.in_mem_read = 1; bus.in_mem_write = 1;
    step();
    chk("rw_mem_read", 16'(bus.out_mem_read), 16'h1);
    chk("rw_mem_write", 16'(bus.out_mem_write), 16'h1);
    bus.in_mem_read = 0; bus.in_mem_write = 0;
    bus.in_halt = 1; bus.alu_out = 16'h0042;
    step();
    chk("halt_out_halt", 16'(bus.out_halt), 16'h1);
    chk("halt_valid", 16'(bus.out_valid), 16'h1);
    chk("halt_result", bus.out_result, 16'h0042);
    bus.in_halt = 0;
    for (int i = 0; i < 2; i++) begin
      bus.alu_out = 16'(16'h0100 + i);
      step();
      chk("halted_valid", 16'(bus.out_valid), 16'h0);
      chk("halted_halt", 16'(bus.out_halt), 16'h1);
      chk("halted_result", bus.out_result, 16'h0);
    end
    rst = 1; bus.stall = 1;
    step();
    chk("rst_clears_halt", 16'(bus.out_halt), 16'h0);
    rst = 0; bus.stall = 0;
    bus.in_halt = 1; bus.flush = 1;
    step();
    chk("flushhalt_halt", 16'(bus.out_halt), 16'h0);
    chk("flushhalt_valid", 16'(bus.out_valid), 16'h0);
    bus.flush = 0; bus.in_halt = 0; bus.alu_out = 16'h0077;
    step();
    chk("after_valid", 16'(bus.out_valid), 16'h1);
    chk("after_result", bus.out_result, 16'h0077);
    chk("after_halt", 16'(bus.out_halt), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
